wb_reg_bank: RTL and testbench

//  Parametrised Wishbone register bank: NREGS 32-bit registers (RW or RO per

---
 rtl/wb_reg_bank_if.sv | 17 +
 rtl/wb_reg_bank.sv | 107 ++++++++++
 tb/tb_wb_reg_bank.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_reg_bank_if.sv
// wb_if: Wishbone bus bundle between a master and the wb_reg_bank slave.
//  master drives cyc/stb/we/adr/sel/dato; slave drives dati/ack/err/rty/stall.
interface wb_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dato;
   logic [31:0] dati;
   logic        ack;
   logic        err;
   logic        rty;
   logic        stall;
   modport master (output cyc, stb, we, adr, sel, dato, input dati, ack, err, rty, stall);
   modport slave  (input cyc, stb, we, adr, sel, dato, output dati, ack, err, rty, stall);
endinterface

// File: rtl/wb_reg_bank.sv
// wb_reg_bank: NREGS x 32-bit RW/RO register bank behind a Wishbone slave.
//  clk, rst_n : clock, asynchronous active-low reset
//  wb         : Wishbone slave (cyc/stb/we/adr/sel/dato in; dati/ack/err/rty/stall out)
//  regs_o     : RW register values (RO slices read as 0)
//  ro_i       : status words returned for RO registers
//  wstb_o     : one-cycle pulse per register written
module wb_reg_bank #(
   parameter int                  NREGS   = 4,
   parameter int                  PIPE_WR = 1,
   parameter int                  PIPE_RD = 1,
   parameter logic [NREGS-1:0]    RO_MASK = '0,
   parameter logic [NREGS*32-1:0] RST_VAL = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   wb_if.slave                 wb,
   output logic [NREGS*32-1:0] regs_o,
   input  logic [NREGS*32-1:0] ro_i,
   output logic [NREGS-1:0]    wstb_o
);
   // index decode is one bit wider than a power-of-two bank needs, so the
   // first word past the bank reports err instead of aliasing register 0
   localparam int AW = $clog2(NREGS + 1);
   logic [31:0]   r [NREGS];
   logic          en, rd_req, wr_req, rip, wip, idx_ok;
   logic [AW-1:0] idx;
   logic          p_v;
   logic [AW-1:0] p_idx;
   logic [31:0]   p_dat;
   logic [3:0]    p_sel;
   logic          d_v, d_ok;
   logic [AW-1:0] d_idx;
   logic [31:0]   d_dat;
   logic [3:0]    d_sel;
   logic          wack, werr, rack_q, rerr_q, rack, rerr;
   logic [31:0]   rdat, dati_q;
   assign en     = wb.cyc & wb.stb;
   assign rd_req = en & ~wb.we & ~rip;
   assign wr_req = en & wb.we & ~wip;
   assign idx    = wb.adr[AW+1:2];
   assign idx_ok = 32'(idx) < NREGS;
   // write decode works on the staged request or straight off the bus
   assign d_v   = (PIPE_WR != 0) ? p_v   : wr_req;
   assign d_idx = (PIPE_WR != 0) ? p_idx : idx;
   assign d_dat = (PIPE_WR != 0) ? p_dat : wb.dato;
   assign d_sel = (PIPE_WR != 0) ? p_sel : wb.sel;
   assign d_ok  = 32'(d_idx) < NREGS;
   assign rack = (PIPE_RD != 0) ? rack_q : rd_req & idx_ok;
   assign rerr = (PIPE_RD != 0) ? rerr_q : rd_req & ~idx_ok;
   assign wb.ack   = wack | rack;
   assign wb.err   = werr | rerr;
   assign wb.rty   = 1'b0;
   assign wb.stall = en & ~(wack | rack | werr | rerr);
   assign wb.dati  = (PIPE_RD != 0) ? dati_q : (rd_req ? rdat : '0);
   always_comb begin
      rdat = '0;
      for (int i = 0; i < NREGS; i++)
         if (idx == AW'(i)) rdat = RO_MASK[i] ? ro_i[32*i +: 32] : r[i];
   end
   always_comb begin
      regs_o = '0;
      for (int i = 0; i < NREGS; i++)
         regs_o[32*i +: 32] = RO_MASK[i] ? '0 : r[i];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_v    <= 1'b0;
         p_idx  <= '0;
         p_dat  <= '0;
         p_sel  <= '0;
         wack   <= 1'b0;
         werr   <= 1'b0;
         wip    <= 1'b0;
         wstb_o <= '0;
         for (int i = 0; i < NREGS; i++) r[i] <= RST_VAL[32*i +: 32];
      end else begin
         p_v <= wr_req;
         if (wr_req) begin
            p_idx <= idx;
            p_dat <= wb.dato;
            p_sel <= wb.sel;
         end
         wack <= d_v & d_ok;
         werr <= d_v & ~d_ok;
         wip  <= (wip | wr_req) & ~(wack | werr);
         for (int i = 0; i < NREGS; i++) begin
            wstb_o[i] <= d_v && d_idx == AW'(i) && !RO_MASK[i];
            for (int b = 0; b < 4; b++)
               if (d_v && d_idx == AW'(i) && !RO_MASK[i] && d_sel[b]) r[i][8*b +: 8] <= d_dat[8*b +: 8];
         end
      end
   end
   // a combinational read acks in its request cycle, so rip never sets then
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rack_q <= 1'b0;
         rerr_q <= 1'b0;
         rip    <= 1'b0;
         dati_q <= '0;
      end else begin
         rack_q <= rd_req & idx_ok;
         rerr_q <= rd_req & ~idx_ok;
         rip    <= (rip | rd_req) & ~(rack | rerr);
         if (rd_req) dati_q <= rdat;
      end
   end
endmodule

// File: tb/tb_wb_reg_bank.sv
// tb_wb_reg_bank: table-driven scoreboard bench for two wb_reg_bank configurations.
module tb_wb_reg_bank;
   typedef struct {
      bit          d;
      bit          we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          lat;
      bit          ack;
      bit          err;
      logic [31:0] dati;
      logic [3:0]  wstb;
      int          ridx;
      logic [31:0] rval;
   } vec_t;
   localparam logic [127:0] RV = {64'h0, 32'h0000_00A5, 32'h0};
   logic         clk = 0, rst_n = 0;
   logic         cyc = 0, stb = 0, we = 0, dsel = 0;
   logic [31:0]  adr = 0, dato = 0;
   logic [3:0]   sel = 0;
   logic [127:0] regs0, regs1, ro;
   logic [3:0]   wstb0, wstb1;
   int           checks = 0, failures = 0;
   vec_t         vt [18];
   vec_t         sb [$];
   wb_if wb0();
   wb_if wb1();
   always #5 clk = ~clk;
   assign ro = {32'h1234_5678, 96'h0};
   assign wb0.cyc = cyc & ~dsel;
   assign wb0.stb = stb & ~dsel;
   assign wb0.we = we;
   assign wb0.adr = adr;
   assign wb0.sel = sel;
   assign wb0.dato = dato;
   assign wb1.cyc = cyc & dsel;
   assign wb1.stb = stb & dsel;
   assign wb1.we = we;
   assign wb1.adr = adr;
   assign wb1.sel = sel;
   assign wb1.dato = dato;
   wb_reg_bank #(.NREGS(4), .PIPE_WR(1), .PIPE_RD(1), .RO_MASK(4'b1000), .RST_VAL(RV)) u0 (
      .clk(clk), .rst_n(rst_n), .wb(wb0), .regs_o(regs0), .ro_i(ro), .wstb_o(wstb0));
   wb_reg_bank #(.NREGS(4), .PIPE_WR(0), .PIPE_RD(0), .RO_MASK(4'b1000), .RST_VAL(RV)) u1 (
      .clk(clk), .rst_n(rst_n), .wb(wb1), .regs_o(regs1), .ro_i(ro), .wstb_o(wstb1));
   logic         ack_o, err_o, rty_o, stall_o;
   logic [31:0]  dati_o;
   logic [127:0] regs_o;
   logic [3:0]   wstb_o;
   assign ack_o   = dsel ? wb1.ack : wb0.ack;
   assign err_o   = dsel ? wb1.err : wb0.err;
   assign rty_o   = dsel ? wb1.rty : wb0.rty;
   assign stall_o = dsel ? wb1.stall : wb0.stall;
   assign dati_o  = dsel ? wb1.dati : wb0.dati;
   assign regs_o  = dsel ? regs1 : regs0;
   assign wstb_o  = dsel ? wstb1 : wstb0;
   function automatic vec_t mk(bit d, bit w, logic [31:0] a, logic [31:0] dt, logic [3:0] s, int l,
                               bit ak, bit er, logic [31:0] di, logic [3:0] ws, int ri, logic [31:0] rv);
      vec_t v;
      v = '{d, w, a, dt, s, l, ak, er, di, ws, ri, rv};
      return v;
   endfunction
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", n, act, exp);
      end
   endtask
   // one transfer, stb held until the response is seen; lat counts cycles from request
   task automatic xfer(input vec_t v, output int lat, output logic a, output logic e, output logic r_rty,
                       output logic [31:0] d, output logic [3:0] w, output logic [127:0] r);
      @(posedge clk);
      #1;
      dsel = v.d; cyc = 1; stb = 1; we = v.we; adr = v.adr; dato = v.dat; sel = v.sel;
      lat = -1; a = 0; e = 0; r_rty = 0; d = 0; w = 0; r = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         r_rty = r_rty | rty_o;
         if (ack_o | err_o) begin
            lat = n; a = ack_o; e = err_o; d = dati_o; w = wstb_o; r = regs_o;
            break;
         end
      end
      @(posedge clk);
      #1;
      cyc = 0; stb = 0; we = 0;
   endtask
   task automatic apply(input vec_t v, input int id);
      vec_t e;
      int lat;
      logic a, er, ry;
      logic [31:0] d;
      logic [3:0] w;
      logic [127:0] r;
      sb.push_back(v);
      xfer(v, lat, a, er, ry, d, w, r);
      e = sb.pop_front();
      chk($sformatf("v%0d latency", id), 32'(lat), 32'(e.lat));
      chk($sformatf("v%0d ack", id), 32'(a), 32'(e.ack));
      chk($sformatf("v%0d err", id), 32'(er), 32'(e.err));
      chk($sformatf("v%0d rty", id), 32'(ry), 32'd0);
      chk($sformatf("v%0d wstb", id), 32'(w), 32'(e.wstb));
      if (!e.we) chk($sformatf("v%0d dati", id), d, e.dati);
      if (e.ridx >= 0) chk($sformatf("v%0d reg", id), r[32*e.ridx +: 32], e.rval);
   endtask
   initial begin
      int n;
      bit seen;
      vt[0]  = mk(0, 0, 32'h4,   32'h0,        4'h0, 1, 1, 0, 32'hA5,        4'h0, -1, 0);
      vt[1]  = mk(0, 1, 32'h4,   32'hDEADBEEF, 4'hF, 2, 1, 0, 0,             4'h2,  1, 32'hDEADBEEF);
      vt[2]  = mk(0, 0, 32'h4,   32'h0,        4'h0, 1, 1, 0, 32'hDEADBEEF,  4'h0, -1, 0);
      vt[3]  = mk(0, 1, 32'h8,   32'hAAAAAAAA, 4'hF, 2, 1, 0, 0,             4'h4,  2, 32'hAAAAAAAA);
      vt[4]  = mk(0, 1, 32'h8,   32'h11223344, 4'h5, 2, 1, 0, 0,             4'h4,  2, 32'hAA22AA44);
      vt[5]  = mk(0, 1, 32'h8,   32'h99999999, 4'h0, 2, 1, 0, 0,             4'h4,  2, 32'hAA22AA44);
      vt[6]  = mk(0, 0, 32'h10,  32'h0,        4'h0, 1, 0, 1, 0,             4'h0, -1, 0);
      vt[7]  = mk(0, 1, 32'h10,  32'h5555AAAA, 4'hF, 2, 0, 1, 0,             4'h0,  2, 32'hAA22AA44);
      vt[8]  = mk(0, 0, 32'hC,   32'h0,        4'h0, 1, 1, 0, 32'h12345678,  4'h0, -1, 0);
      vt[9]  = mk(0, 1, 32'hC,   32'hFFFFFFFF, 4'hF, 2, 1, 0, 0,             4'h0,  3, 32'h0);
      vt[10] = mk(0, 0, 32'h0,   32'h0,        4'h0, 1, 1, 0, 32'h0,         4'h0, -1, 0);
      vt[11] = mk(0, 0, 32'h107, 32'h0,        4'h0, 1, 1, 0, 32'hDEADBEEF,  4'h0, -1, 0);
      vt[12] = mk(1, 1, 32'h0,   32'hCAFEF00D, 4'hF, 1, 1, 0, 0,             4'h1,  0, 32'hCAFEF00D);
      vt[13] = mk(1, 0, 32'h0,   32'h0,        4'h0, 0, 1, 0, 32'hCAFEF00D,  4'h0, -1, 0);
      vt[14] = mk(1, 0, 32'h10,  32'h0,        4'h0, 0, 0, 1, 0,             4'h0, -1, 0);
      vt[15] = mk(1, 1, 32'h10,  32'h1,        4'hF, 1, 0, 1, 0,             4'h0,  0, 32'hCAFEF00D);
      vt[16] = mk(1, 0, 32'h4,   32'h0,        4'h0, 0, 1, 0, 32'hA5,        4'h0, -1, 0);
      vt[17] = mk(0, 1, 32'h4,   32'h0BADF00D, 4'hF, 2, 1, 0, 0,             4'h2,  1, 32'h0BADF00D);
      // reset state on both banks
      repeat (2) @(negedge clk);
      dsel = 0;
      #1;
      chk("rst0 reg1", regs_o[63:32], 32'hA5);
      chk("rst0 dati", dati_o, 32'h0);
      chk("rst0 ack", 32'(ack_o), 32'h0);
      chk("rst0 wstb", 32'(wstb_o), 32'h0);
      dsel = 1;
      #1;
      chk("rst1 reg1", regs_o[63:32], 32'hA5);
      chk("rst1 ack", 32'(ack_o | err_o), 32'h0);
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < 17; i++) apply(vt[i], i);
      // cyc dropped after the request cycle: write still lands and acks once
      @(posedge clk);
      #1;
      dsel = 0; cyc = 1; stb = 1; we = 1; adr = 32'h8; dato = 32'h55AA55AA; sel = 4'hF;
      @(negedge clk);
      chk("drop stall", 32'(stall_o), 32'h1);
      @(posedge clk);
      #1;
      cyc = 0; stb = 0; we = 0;
      n = -1;
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         if (ack_o) begin
            n = k;
            break;
         end
      end
      chk("drop latency", 32'(n), 32'd2);
      chk("drop reg2", regs_o[95:64], 32'h55AA55AA);
      chk("drop wstb", 32'(wstb_o), 32'h4);
      @(negedge clk);
      chk("drop ack once", 32'(ack_o), 32'h0);
      chk("drop wstb once", 32'(wstb_o), 32'h0);
      // stall held during a pipelined read, released in its ack cycle
      @(posedge clk);
      #1;
      cyc = 1; stb = 1; we = 0; adr = 32'h8;
      @(negedge clk);
      chk("rd stall c0", 32'(stall_o), 32'h1);
      chk("rd ack c0", 32'(ack_o), 32'h0);
      @(negedge clk);
      chk("rd stall c1", 32'(stall_o), 32'h0);
      chk("rd ack c1", 32'(ack_o), 32'h1);
      chk("rd dati c1", dati_o, 32'h55AA55AA);
      @(posedge clk);
      #1;
      cyc = 0; stb = 0;
      // reset during the staged cycle of a write: dropped, no ack
      @(posedge clk);
      #1;
      cyc = 1; stb = 1; we = 1; adr = 32'h4; dato = 32'h0BADF00D; sel = 4'hF;
      @(posedge clk);
      #1;
      rst_n = 0; cyc = 0; stb = 0; we = 0;
      seen = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         seen = seen | ack_o | err_o;
      end
      chk("rstmid ack", 32'(seen), 32'h0);
      chk("rstmid reg1", regs_o[63:32], 32'hA5);
      rst_n = 1;
      apply(vt[17], 17);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
